mc_control_unit: RTL
====================

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Parameter ALUOP_W, default 4: ALU_OP width; opcode values fit in 4 bits, upper bits zero.
REQ-002 Parameter TO_W, default 4: wait-timeout counter width; timeout after 2^TO_W-1 consecutive not-ready cycles.
REQ-003 Parameter CNT_W, default 32: retired-instruction counter width.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_  in  1  asynchronous, active-low reset.
REQ-006 opcode/func3/func7  in  7/3/7  decoded IR fields.
REQ-007 ZF, SF, CF, OF  in  1 each  registered ALU flags; CF = borrow on SUB.
REQ-008 im_ready, dm_ready  in  1  instruction/data memory done.
REQ-009 im_req, dm_req  out  1  memory request, held until ready or timeout.
REQ-010 PC_Write, PC0_Write, IR_Write, Reg_Write, Mem_write  out  1  write enables.
REQ-011 ALU_OP  out  ALUOP_W  ALU operation; SE_s out 1; Size_s out 2; PC_s out 2 (0 PC+4, 1 PC0+imm, 2 F); rs2_imm_s out 1; w_data_s out 3 (0 F, 1 imm, 2 MDR, 3 PC, 4 PC0+imm).
REQ-012 bus_err  out  1  sticky timeout flag; trap  out  1  illegal-instruction flag; state  out  4  current state; icount  out  CNT_W  retired count.

Function
REQ-013 States: IF, ID, EX, BR, MEM, WB, TRAP; all outputs decoded from state (plus fields/flags), Moore except where stated.
REQ-014 IF: im_req=1; in the im_ready cycle IR_Write=PC0_Write=PC_Write=1, PC_s=0, go ID; else stay.
REQ-015 ID: one cycle, no enables; next by opcode: R/I-ALU/LOAD/STORE/BRANCH/JALR->EX; LUI/AUIPC/JAL->WB; other->illegal handling (REQ-027).
REQ-016 EX: ALU_OP={func7[5],func3} for R; I-ALU same but bit3 forced 0 unless func3=101; LOAD/STORE/JALR ADD(0) with rs2_imm_s=1; BRANCH SUB(8), rs2_imm_s=0. Next: BRANCH->BR, LOAD/STORE->MEM, else WB.
REQ-017 BR: PC_Write=1, PC_s=1 iff taken (BEQ ZF, BNE !ZF, BLT SF^OF, BGE !(SF^OF), BLTU CF, BGEU !CF); ->IF.
REQ-018 MEM: dm_req=1, Size_s=func3[1:0], SE_s=!func3[2]; STORE holds Mem_write=1 with dm_req; on dm_ready LOAD->WB, STORE->IF.
REQ-019 WB: Reg_Write=1; w_data_s: R/I-ALU 0, LUI 1, LOAD 2, JAL/JALR 3, AUIPC 4; JAL also PC_Write, PC_s=1; JALR PC_Write, PC_s=2; ->IF.
REQ-020 Writes with rd=0 are issued; register file discards them.
REQ-021 icount increments by 1 on every transition into IF from BR, MEM(store), WB; wraps at 2^CNT_W.
REQ-022 Wait counter clears on entering IF/MEM and on ready; at 2^TO_W-1 not-ready cycles: bus_err=1, drop request, skip instruction ->IF, no enables, icount unchanged.
REQ-023 Ready asserted in the request's first cycle: zero-wait, no stall cycle.
REQ-024 Minimum latency: ALU 4 cycles, LOAD 5, STORE 4, BRANCH 4, LUI/AUIPC/JAL 3.

Reset
REQ-025 rst_ low: state=IF, all enables 0, ALU_OP=0, selects 0, bus_err=0, trap=0, icount=0, wait counter=0, immediately and asynchronously.
REQ-026 Reset mid-MEM drops Mem_write same cycle; no partial commit beyond reset assertion.

Configuration
REQ-027 Macro MC_CTRL_TRAP_EN defined: illegal opcode ->TRAP, trap=1, all enables 0, held until reset; undefined: illegal opcode ->IF as NOP, counted in icount, TRAP unreachable, trap tied 0.

Structure
REQ-028 Shared package mc_pkg: state enum, opcode constants, ALU_OP constants, PC_s and w_data_s select constants.
REQ-029 One sub-module mc_branch_cond: combinational func3+flags -> taken.

Verification
REQ-030 ADD x3,x1,x2 (0110011/000/0000000), im_ready=dm_ready=1 -> states IF,ID,EX,WB; ALU_OP=0; WB Reg_Write=1, w_data_s=0; icount 0->1.
REQ-031 SUB R-type func7=0100000 -> ALU_OP=8; SRAI func3=101 func7[5]=1 -> 13; ADDI func7 bits set -> 0.
REQ-032 BLT, SF=1 OF=0 -> BR PC_Write=1 PC_s=1; SF=1 OF=1 -> PC_Write=0.
REQ-033 LW, dm_ready low 3 cycles -> dm_req held 4 cycles, WB w_data_s=2, Size_s=2, SE_s=1; total 8 cycles.
REQ-034 im_ready never, TO_W=4 -> bus_err=1 after 15 wait cycles, im_req drops, icount unchanged.
REQ-035 opcode 1111111 -> TRAP, trap=1 with MC_CTRL_TRAP_EN; without it, back to IF, icount+1; rst_ low clears.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle control unit: FSM state encoding,
// RV32I major opcodes, ALU operation codes and datapath select encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    StIf   = 4'd0,
    StId   = 4'd1,
    StEx   = 4'd2,
    StBr   = 4'd3,
    StMem  = 4'd4,
    StWb   = 4'd5,
    StTrap = 4'd6
  } mc_state_e;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [3:0] AluAdd = 4'd0;
  localparam logic [3:0] AluSub = 4'd8;

  // PC_s encodings
  localparam logic [1:0] PcPlus4  = 2'd0;
  localparam logic [1:0] PcPc0Imm = 2'd1;
  localparam logic [1:0] PcAlu    = 2'd2;

  // w_data_s encodings
  localparam logic [2:0] WdAlu    = 3'd0;
  localparam logic [2:0] WdImm    = 3'd1;
  localparam logic [2:0] WdMdr    = 3'd2;
  localparam logic [2:0] WdPc     = 3'd3;
  localparam logic [2:0] WdPc0Imm = 3'd4;

  // Opcodes that need an ALU pass in EX before committing.
  function automatic logic needs_ex(input logic [6:0] op);
    return op inside {OpR, OpImm, OpLoad, OpStore, OpBranch, OpJalr};
  endfunction

  // Opcodes whose result is ready straight after decode.
  function automatic logic direct_wb(input logic [6:0] op);
    return op inside {OpLui, OpAuipc, OpJal};
  endfunction

endpackage

// File: rtl/mc_branch_cond.sv
// Branch condition evaluation from func3 and the flags of the EX-stage SUB.
module mc_branch_cond (
  input  logic [2:0] func3,
  input  logic       ZF,
  input  logic       SF,
  input  logic       CF,
  input  logic       OF,
  output logic       taken
);

  // Signed compares use SF^OF; unsigned compares use the SUB borrow.
  always_comb begin
    taken = 1'b0;
    case (func3)
      3'b000:  taken = ZF;
      3'b001:  taken = !ZF;
      3'b100:  taken = SF ^ OF;
      3'b101:  taken = !(SF ^ OF);
      3'b110:  taken = CF;
      3'b111:  taken = !CF;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control unit: IF -> ID -> {EX -> {BR, MEM, WB}, WB} -> IF.
// Memory waits are bounded by a timeout that raises a sticky bus_err and skips
// the instruction. Optional feature macro MC_CTRL_TRAP_EN: when defined, an
// illegal opcode parks the FSM in TRAP until reset; otherwise it retires as a NOP.
module mc_control_unit
  import mc_pkg::*;
#(
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned TO_W    = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic [6:0]         opcode,
  input  logic [2:0]         func3,
  input  logic [6:0]         func7,
  input  logic               ZF,
  input  logic               SF,
  input  logic               CF,
  input  logic               OF,
  input  logic               im_ready,
  input  logic               dm_ready,
  output logic               im_req,
  output logic               dm_req,
  output logic               PC_Write,
  output logic               PC0_Write,
  output logic               IR_Write,
  output logic               Reg_Write,
  output logic               Mem_write,
  output logic [ALUOP_W-1:0] ALU_OP,
  output logic               SE_s,
  output logic [1:0]         Size_s,
  output logic [1:0]         PC_s,
  output logic               rs2_imm_s,
  output logic [2:0]         w_data_s,
  output logic               bus_err,
  output logic               trap,
  output logic [3:0]         state,
  output logic [CNT_W-1:0]   icount
);

  localparam logic [TO_W-1:0] WaitMax = '1;

  mc_state_e        state_q, state_d;
  logic [TO_W-1:0]  wcnt_q, wcnt_d, wcnt_inc;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] icount_q, icount_d;
  logic             timeout;
  logic             taken;
  logic [3:0]       alu_code;
  logic             unused_func7;

  assign unused_func7 = ^{func7[6], func7[4:0]};

  mc_branch_cond u_branch_cond (
    .func3 (func3),
    .ZF    (ZF),
    .SF    (SF),
    .CF    (CF),
    .OF    (OF),
    .taken (taken)
  );

  assign wcnt_inc = wcnt_q + TO_W'(1);
  // The cycle after the last tolerated not-ready cycle drops the request.
  assign timeout  = ((state_q == StIf) || (state_q == StMem)) && (wcnt_q == WaitMax);

  // Next state, wait counter, sticky bus error and retire counter.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = '0;
    bus_err_d = bus_err_q;
    icount_d  = icount_q;
    unique case (state_q)
      StIf: begin
        if (timeout) begin
          state_d = StIf;
        end else if (im_ready) begin
          state_d = StId;
        end else begin
          wcnt_d = wcnt_inc;
          if (wcnt_inc == WaitMax) bus_err_d = 1'b1;
        end
      end
      StId: begin
        if (needs_ex(opcode)) begin
          state_d = StEx;
        end else if (direct_wb(opcode)) begin
          state_d = StWb;
        end else begin
`ifdef MC_CTRL_TRAP_EN
          state_d = StTrap;
`else
          state_d  = StIf;
          icount_d = icount_q + CNT_W'(1);
`endif
        end
      end
      StEx: begin
        if (opcode == OpBranch) begin
          state_d = StBr;
        end else if ((opcode == OpLoad) || (opcode == OpStore)) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StBr: begin
        state_d  = StIf;
        icount_d = icount_q + CNT_W'(1);
      end
      StMem: begin
        if (timeout) begin
          state_d = StIf;
        end else if (dm_ready) begin
          if (opcode == OpStore) begin
            state_d  = StIf;
            icount_d = icount_q + CNT_W'(1);
          end else begin
            state_d = StWb;
          end
        end else begin
          wcnt_d = wcnt_inc;
          if (wcnt_inc == WaitMax) bus_err_d = 1'b1;
        end
      end
      StWb: begin
        state_d  = StIf;
        icount_d = icount_q + CNT_W'(1);
      end
      StTrap: begin
`ifdef MC_CTRL_TRAP_EN
        state_d = StTrap;
`else
        state_d = StIf;
`endif
      end
      default: state_d = StIf;
    endcase
  end

  // Single state register bank for the FSM and its counters.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= StIf;
      wcnt_q    <= '0;
      bus_err_q <= 1'b0;
      icount_q  <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      bus_err_q <= bus_err_d;
      icount_q  <= icount_d;
    end
  end

  // ALU code from instruction fields; bit 3 only survives for R-type and SRAI.
  always_comb begin
    alu_code = AluAdd;
    if (opcode == OpR) begin
      alu_code = {func7[5], func3};
    end else if (opcode == OpImm) begin
      alu_code = {(func3 == 3'b101) ? func7[5] : 1'b0, func3};
    end else if (opcode == OpBranch) begin
      alu_code = AluSub;
    end
  end

  // Output decode; gated by reset so everything is quiet while rst_ is low.
  always_comb begin
    im_req    = 1'b0;
    dm_req    = 1'b0;
    PC_Write  = 1'b0;
    PC0_Write = 1'b0;
    IR_Write  = 1'b0;
    Reg_Write = 1'b0;
    Mem_write = 1'b0;
    ALU_OP    = '0;
    SE_s      = 1'b0;
    Size_s    = 2'd0;
    PC_s      = PcPlus4;
    rs2_imm_s = 1'b0;
    w_data_s  = WdAlu;
    trap      = 1'b0;
    if (rst_) begin
      unique case (state_q)
        StIf: begin
          im_req = !timeout;
          if (im_ready && !timeout) begin
            IR_Write  = 1'b1;
            PC0_Write = 1'b1;
            PC_Write  = 1'b1;
            PC_s      = PcPlus4;
          end
        end
        StEx: begin
          ALU_OP    = ALUOP_W'(alu_code);
          rs2_imm_s = (opcode != OpR) && (opcode != OpBranch);
        end
        StBr: begin
          if (taken) begin
            PC_Write = 1'b1;
            PC_s     = PcPc0Imm;
          end
        end
        StMem: begin
          Size_s = func3[1:0];
          SE_s   = !func3[2];
          if (!timeout) begin
            dm_req    = 1'b1;
            Mem_write = (opcode == OpStore);
          end
        end
        StWb: begin
          Reg_Write = 1'b1;
          case (opcode)
            OpLui:   w_data_s = WdImm;
            OpLoad:  w_data_s = WdMdr;
            OpAuipc: w_data_s = WdPc0Imm;
            OpJal: begin
              w_data_s = WdPc;
              PC_Write = 1'b1;
              PC_s     = PcPc0Imm;
            end
            OpJalr: begin
              w_data_s = WdPc;
              PC_Write = 1'b1;
              PC_s     = PcAlu;
            end
            default: w_data_s = WdAlu;
          endcase
        end
        StTrap: begin
`ifdef MC_CTRL_TRAP_EN
          trap = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus_err = bus_err_q;
  assign icount  = icount_q;
  assign state   = state_q;

endmodule
